// File: rtl/core_frontend_resp_pkg.sv
// ============================================================================
// Module : core_frontend_resp_pkg
// Brief  : Frontend request/response types, instruction register info and
//          cacop encodings shared by the frontend response slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package core_frontend_resp_pkg;

    localparam logic [31:0] C_RESET_PC = 32'h1C00_0000;

    localparam logic [1:0] C_CACOP_IDX_INIT = 2'd0;
    localparam logic [1:0] C_CACOP_IDX_INV  = 2'd1;
    localparam logic [1:0] C_CACOP_HIT_INV  = 2'd2;
    localparam logic [1:0] C_CACOP_NOP      = 2'd3;

    typedef struct packed {
        logic [4:0]      w_reg;
        logic [1:0][4:0] r_reg;
    } reg_info_t;

    typedef struct packed {
        logic [31:0] pc;
        reg_info_t   reg_info;
    } inst_t;

    typedef struct packed {
        logic [1:0]  inst_valid;
        inst_t [1:0] inst;
        logic        icache_ready;
    } frontend_req_t;

    typedef struct packed {
        logic [1:0]  issue;
        logic        rst_jmp;
        logic [31:0] rst_jmp_target;
        logic        icache_op_valid;
        logic [1:0]  icache_op;
        logic [31:0] icacheop_addr;
        logic        wait_inst;
        logic        int_detect;
        logic        bpu_flush;
        logic [31:0] excp_pc;
    } frontend_resp_t;

    // r0 is hardwired zero, so a write to it never creates a dependency.
    function automatic logic raw_hazard(input reg_info_t older, input reg_info_t younger);
        return (older.w_reg != 5'd0) &&
               ((younger.r_reg[0] == older.w_reg) || (younger.r_reg[1] == older.w_reg));
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_issue_pair_check.sv
// ============================================================================
// Module : core_issue_pair_check
// Brief  : Decides whether the second fetched instruction may pair with the
//          first one in the same issue cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module core_issue_pair_check
    import core_frontend_resp_pkg::*;
(
    input  logic       slot0_issue,
    input  logic       inst1_valid,
    input  logic [1:0] be_ready,
    input  reg_info_t  older,
    input  reg_info_t  younger,
    output logic       pair_ok
);

    assign pair_ok = slot0_issue & inst1_valid & (be_ready == 2'd2) & ~raw_hazard(older, younger);

endmodule

`default_nettype wire

// File: rtl/core_frontend_resp.sv
// ============================================================================
// Module : core_frontend_resp
// Brief  : Frontend response generation: issue slots, redirect jump, cacop
//          handshake and idle/interrupt wait. Dual issue via CORE_DUAL_ISSUE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module core_frontend_resp
    import core_frontend_resp_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  frontend_req_t  frontend_req_i,
    output frontend_resp_t frontend_resp_o,
    input  logic [1:0]     be_ready_i,
    input  logic           br_redir_valid_i,
    input  logic [31:0]    br_redir_target_i,
    input  logic           ex_redir_valid_i,
    input  logic [31:0]    ex_redir_target_i,
    input  logic           cop_valid_i,
    input  logic [1:0]     cop_i,
    input  logic [31:0]    cop_paddr_i,
    output logic           cop_ready_o,
    input  logic           idle_i,
    input  logic           int_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } cacop_state_e;

    cacop_state_e r_state;
    logic         r_rst_jmp;
    logic [31:0]  r_rst_jmp_target;
    logic         r_icache_op_valid;
    logic [1:0]   r_icache_op;
    logic [31:0]  r_icacheop_addr;
    logic         r_wait_inst;
    logic         r_int_detect;

    logic         w_slot0;
    logic         w_slot1;
    logic         w_unused_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_rst_jmp         <= 1'b0;
            r_rst_jmp_target  <= C_RESET_PC;
            r_icache_op_valid <= 1'b0;
            r_icache_op       <= 2'd0;
            r_icacheop_addr   <= 32'd0;
            r_wait_inst       <= 1'b0;
            r_int_detect      <= 1'b0;
        end else begin
            r_rst_jmp <= br_redir_valid_i | ex_redir_valid_i;
            if (ex_redir_valid_i)
                r_rst_jmp_target <= ex_redir_target_i;
            else if (br_redir_valid_i)
                r_rst_jmp_target <= br_redir_target_i;

            // Redirects never disturb an in-flight cacop.
            case (r_state)
                S_IDLE: begin
                    if (cop_valid_i) begin
                        r_state           <= S_SEND;
                        r_icache_op_valid <= 1'b1;
                        r_icache_op       <= cop_i;
                        r_icacheop_addr   <= cop_paddr_i;
                    end
                end
                S_SEND: begin
                    r_state           <= S_WAIT;
                    r_icache_op_valid <= 1'b0;
                end
                S_WAIT: begin
                    if (frontend_req_i.icache_ready)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state           <= S_IDLE;
                    r_icache_op_valid <= 1'b0;
                end
            endcase

            if (int_i)
                r_wait_inst <= 1'b0;
            else if (idle_i)
                r_wait_inst <= 1'b1;
            r_int_detect <= int_i;
        end
    end

    assign w_slot0 = ~rst & frontend_req_i.inst_valid[0] & (be_ready_i != 2'd0) & ~r_rst_jmp;

`ifdef CORE_DUAL_ISSUE_EN
    core_issue_pair_check u_pair_check (
        .slot0_issue (w_slot0),
        .inst1_valid (frontend_req_i.inst_valid[1]),
        .be_ready    (be_ready_i),
        .older       (frontend_req_i.inst[0].reg_info),
        .younger     (frontend_req_i.inst[1].reg_info),
        .pair_ok     (w_slot1)
    );
    assign w_unused_req = ^{frontend_req_i.inst[0].pc, frontend_req_i.inst[1].pc};
`else
    assign w_slot1      = 1'b0;
    assign w_unused_req = ^{frontend_req_i.inst, frontend_req_i.inst_valid[1]};
`endif

    // Completion is acknowledged in the same cycle the icache reports ready.
    assign cop_ready_o = ~rst & (r_state == S_WAIT) & frontend_req_i.icache_ready;

    always_comb begin
        frontend_resp_o                 = '0;
        frontend_resp_o.issue           = {w_slot1, w_slot0};
        frontend_resp_o.rst_jmp         = r_rst_jmp;
        frontend_resp_o.rst_jmp_target  = r_rst_jmp_target;
        frontend_resp_o.icache_op_valid = r_icache_op_valid;
        frontend_resp_o.icache_op       = r_icache_op;
        frontend_resp_o.icacheop_addr   = r_icacheop_addr;
        frontend_resp_o.wait_inst       = r_wait_inst;
        frontend_resp_o.int_detect      = r_int_detect;
    end

endmodule

`default_nettype wire
